apb_master_bridge: RTL and testbench

- Converts a simple valid/ready command interface into APB (AMBA 3) transfers toward the existing apb_slave register block.
- Returns read data and slave error on a one-cycle response strobe.
- Sits between the system-side requester (CPU/test sequencer) and apb_slave.
- Owns the SETUP/ACCESS phase sequencing and wait-state handling.

---
 rtl/apb_pkg.sv | 24 ++
 rtl/apb_timeout_counter.sv | 42 ++++
 rtl/apb_master_bridge.sv | 147 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_pkg: shared APB constants, register map addresses and bridge FSM states.
// Revision: 1.0
// ----------------------------------------------------------------------------
package apb_pkg;

   localparam int APB_ADDR_W = 2;
   localparam int APB_DATA_W = 32;

   // Register map of the downstream apb_slave block.
   localparam logic [APB_ADDR_W-1:0] ADDR_RO    = 2'b00;
   localparam logic [APB_ADDR_W-1:0] ADDR_WO    = 2'b01;
   localparam logic [APB_ADDR_W-1:0] ADDR_RW    = 2'b10;
   localparam logic [APB_ADDR_W-1:0] ADDR_FIXED = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

endpackage
`default_nettype wire

// File: rtl/apb_timeout_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_timeout_counter: counts ACCESS wait cycles, flags the last allowed one.
// Revision: 1.0
// ----------------------------------------------------------------------------
module apb_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic p_clk,
   input  logic p_reset_n,
   input  logic clear,
   input  logic wait_cycle,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Expiry fires on the TIMEOUT_CYCLES-th consecutive wait cycle.
   assign expired = wait_cycle && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (wait_cycle && !expired) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge p_clk or negedge p_reset_n) begin
      if (!p_reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_master_bridge: valid/ready command port to APB3 master (SETUP/ACCESS).
// Optional APB_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYCLES wait cycles. Rev 1.0
// ----------------------------------------------------------------------------
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int ADDR_W         = APB_ADDR_W,
   parameter int DATA_W         = APB_DATA_W,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              p_clk,
   input  logic              p_reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              p_sel,
   output logic              p_enable,
   output logic              p_write,
   output logic [ADDR_W-1:0] p_addr,
   output logic [DATA_W-1:0] p_w_data,
   input  logic              p_ready,
   input  logic [DATA_W-1:0] p_r_data,
   input  logic              p_slv_err
);

   apb_state_e        state_q, state_d;
   logic              p_sel_q, p_sel_d;
   logic              p_enable_q, p_enable_d;
   logic              p_write_q, p_write_d;
   logic [ADDR_W-1:0] p_addr_q, p_addr_d;
   logic [DATA_W-1:0] p_w_data_q, p_w_data_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              timeout_hit;

`ifdef APB_TIMEOUT_EN
   apb_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .p_clk      (p_clk),
      .p_reset_n  (p_reset_n),
      .clear      (state_q == ST_SETUP),
      .wait_cycle ((state_q == ST_ACCESS) && !p_ready),
      .expired    (timeout_hit)
   );
`else
   // Without the timeout option ACCESS waits for p_ready indefinitely.
   assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

   // Gated by reset so that every output reads 0 while reset is held.
   assign cmd_ready = (state_q == ST_IDLE) && p_reset_n;

   always_comb begin
      state_d     = state_q;
      p_sel_d     = p_sel_q;
      p_enable_d  = p_enable_q;
      p_write_d   = p_write_q;
      p_addr_d    = p_addr_q;
      p_w_data_d  = p_w_data_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               p_write_d  = cmd_write;
               p_addr_d   = cmd_addr;
               p_w_data_d = cmd_wdata;
               p_sel_d    = 1'b1;
               p_enable_d = 1'b0;
               state_d    = ST_SETUP;
            end
         end
         ST_SETUP: begin
            p_enable_d = 1'b1;
            state_d    = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (p_ready) begin
               p_sel_d     = 1'b0;
               p_enable_d  = 1'b0;
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = p_slv_err;
               rsp_rdata_d = p_write_q ? '0 : p_r_data;
            end else if (timeout_hit) begin
               p_sel_d     = 1'b0;
               p_enable_d  = 1'b0;
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
            end
         end
         default: begin
            p_sel_d    = 1'b0;
            p_enable_d = 1'b0;
            state_d    = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge p_clk or negedge p_reset_n) begin
      if (!p_reset_n) begin
         state_q     <= ST_IDLE;
         p_sel_q     <= 1'b0;
         p_enable_q  <= 1'b0;
         p_write_q   <= 1'b0;
         p_addr_q    <= '0;
         p_w_data_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         p_sel_q     <= p_sel_d;
         p_enable_q  <= p_enable_d;
         p_write_q   <= p_write_d;
         p_addr_q    <= p_addr_d;
         p_w_data_q  <= p_w_data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign p_sel     = p_sel_q;
   assign p_enable  = p_enable_q;
   assign p_write   = p_write_q;
   assign p_addr    = p_addr_q;
   assign p_w_data  = p_w_data_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_apb_master_bridge: directed and random transfers against a register model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_apb_master_bridge;
   import apb_pkg::*;

   localparam logic [31:0] C_RO_VAL    = 32'h0000_5A5A;
   localparam logic [31:0] C_FIXED_VAL = 32'hF1ED_0003;

   logic        p_clk = 1'b0;
   logic        p_reset_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [1:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        p_sel, p_enable, p_write;
   logic [1:0]  p_addr;
   logic [31:0] p_w_data;
   logic        p_ready, p_slv_err;
   logic [31:0] p_r_data;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Register model of the slave and last-seen bridge outputs.
   logic [31:0] rw_reg = 32'h0;
   logic [31:0] last_rdata = 32'h0;
   logic        last_err   = 1'b0;
   logic [1:0]  last_addr  = 2'b00;
   logic        last_write = 1'b0;
   logic [31:0] last_wdata = 32'h0;

   apb_master_bridge #(
      .ADDR_W(2), .DATA_W(32), .TIMEOUT_CYCLES(16)
   ) dut (
      .p_clk(p_clk), .p_reset_n(p_reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .p_sel(p_sel), .p_enable(p_enable), .p_write(p_write),
      .p_addr(p_addr), .p_w_data(p_w_data),
      .p_ready(p_ready), .p_r_data(p_r_data), .p_slv_err(p_slv_err)
   );

   always #5 p_clk = ~p_clk;
   always @(posedge p_clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before 2ms");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Behaviour of the apb_slave register map.
   task automatic slave_model(input bit wr, input logic [1:0] a, input logic [31:0] d,
                              output logic [31:0] rd, output bit er);
      rd = 32'h0;
      er = 1'b0;
      case (a)
         ADDR_RO:    if (wr) er = 1'b1; else rd = C_RO_VAL;
         ADDR_WO:    rd = 32'h0;
         ADDR_RW:    if (wr) rw_reg = d; else rd = rw_reg;
         default:    if (!wr) rd = C_FIXED_VAL;
      endcase
   endtask

   task automatic garble_slave();
      p_ready   = 1'($urandom);
      p_r_data  = $urandom;
      p_slv_err = 1'($urandom);
   endtask

   // Starts at a negedge with the bridge idle; ends at the negedge of rsp_valid.
   task automatic xfer(input bit wr, input logic [1:0] a, input logic [31:0] d,
                       input int waits, input bit hold_valid);
      logic [31:0] rd;
      bit          er;
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
      garble_slave();
      @(negedge p_clk);
      last_addr = a; last_write = wr; last_wdata = d;
      chk("setup_rsp_valid", rsp_valid, 0);
      chk("setup_rsp_rdata_hold", rsp_rdata, last_rdata);
      chk("setup_rsp_err_hold", rsp_err, last_err);
      chk("setup_p_sel", p_sel, 1);
      chk("setup_p_enable", p_enable, 0);
      chk("setup_cmd_ready", cmd_ready, 0);
      chk("setup_p_addr", p_addr, a);
      chk("setup_p_write", p_write, wr);
      chk("setup_p_w_data", p_w_data, d);
      cmd_valid = hold_valid; cmd_write = 1'($urandom);
      cmd_addr = 2'($urandom); cmd_wdata = $urandom;
      garble_slave();
      @(negedge p_clk);
      for (int w = 0; w <= waits; w++) begin
         chk("access_p_sel", p_sel, 1);
         chk("access_p_enable", p_enable, 1);
         chk("access_p_addr", p_addr, a);
         chk("access_p_write", p_write, wr);
         chk("access_p_w_data", p_w_data, d);
         chk("access_rsp_valid", rsp_valid, 0);
         chk("access_cmd_ready", cmd_ready, 0);
         if (w < waits) begin
            p_ready = 1'b0; p_r_data = $urandom; p_slv_err = 1'($urandom);
            @(negedge p_clk);
         end
      end
      slave_model(wr, a, d, rd, er);
      p_ready = 1'b1; p_r_data = wr ? $urandom : rd; p_slv_err = er;
      @(negedge p_clk);
      p_ready = 1'b0;
      last_rdata = wr ? 32'h0 : rd;
      last_err   = er;
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_rdata", rsp_rdata, last_rdata);
      chk("rsp_err", rsp_err, last_err);
      chk("rsp_p_sel", p_sel, 0);
      chk("rsp_p_enable", p_enable, 0);
      chk("rsp_cmd_ready", cmd_ready, 1);
      chk("rsp_p_addr_hold", p_addr, a);
      cmd_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      cmd_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         garble_slave();
         @(negedge p_clk);
         chk("idle_rsp_valid", rsp_valid, 0);
         chk("idle_p_sel", p_sel, 0);
         chk("idle_p_enable", p_enable, 0);
         chk("idle_p_addr_hold", p_addr, last_addr);
         chk("idle_p_write_hold", p_write, last_write);
         chk("idle_p_w_data_hold", p_w_data, last_wdata);
         chk("idle_rsp_rdata_hold", rsp_rdata, last_rdata);
         chk("idle_rsp_err_hold", rsp_err, last_err);
      end
   endtask

   initial begin
      int t0;
      logic [31:0] rd;
      bit          er;

      p_reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 2'b00;
      cmd_wdata = 32'h0; p_ready = 1'b0; p_r_data = 32'h0; p_slv_err = 1'b0;
      repeat (3) @(negedge p_clk);
      chk("reset_cmd_ready", cmd_ready, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_rdata", rsp_rdata, 0);
      chk("reset_rsp_err", rsp_err, 0);
      chk("reset_p_sel", p_sel, 0);
      chk("reset_p_enable", p_enable, 0);
      chk("reset_p_write", p_write, 0);
      chk("reset_p_addr", p_addr, 0);
      chk("reset_p_w_data", p_w_data, 0);
      p_reset_n = 1'b1;
      idle_cycles(2);

      // Write then read back the RW register, zero wait states.
      xfer(1'b1, ADDR_RW, 32'd16, 0, 1'b0);
      xfer(1'b0, ADDR_RW, $urandom, 0, 1'b0);
      chk("readback_rw_16", last_rdata, 32'd16);
      idle_cycles(1);

      // Read with three wait states.
      xfer(1'b0, ADDR_RW, $urandom, 3, 1'b0);
      idle_cycles(1);

      // Slave error on read-only, writes to fixed register ignored.
      xfer(1'b1, ADDR_RO, 32'd22, 0, 1'b0);
      chk("ro_write_err", last_err, 1);
      xfer(1'b1, ADDR_FIXED, 32'd20, 0, 1'b0);
      xfer(1'b0, ADDR_FIXED, $urandom, 0, 1'b0);
      chk("fixed_read_value", last_rdata, C_FIXED_VAL);
      idle_cycles(2);

      // Four back-to-back commands with cmd_valid held high throughout.
      t0 = cyc;
      xfer(1'b1, ADDR_RW, 32'hA1, 0, 1'b1);
      xfer(1'b0, ADDR_RW, 32'h0, 0, 1'b1);
      xfer(1'b0, ADDR_RO, 32'h0, 0, 1'b1);
      xfer(1'b1, ADDR_WO, 32'h5, 0, 1'b1);
      chk("b2b_cycles", 32'(cyc - t0), 32'd12);
      idle_cycles(1);

      // Reset asserted during ACCESS aborts silently.
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = ADDR_RW; cmd_wdata = 32'h0;
      @(negedge p_clk);
      cmd_valid = 1'b0; p_ready = 1'b0;
      @(negedge p_clk);
      chk("pre_abort_p_enable", p_enable, 1);
      #2 p_reset_n = 1'b0;
      #1;
      chk("abort_p_sel", p_sel, 0);
      chk("abort_p_enable", p_enable, 0);
      chk("abort_rsp_valid", rsp_valid, 0);
      chk("abort_cmd_ready", cmd_ready, 0);
      chk("abort_rsp_rdata", rsp_rdata, 0);
      @(negedge p_clk);
      p_reset_n = 1'b1;
      last_rdata = 32'h0; last_err = 1'b0;
      last_addr = 2'b00; last_write = 1'b0; last_wdata = 32'h0;
      idle_cycles(3);
      xfer(1'b0, ADDR_RW, $urandom, 1, 1'b0);
      chk("post_abort_read", last_rdata, 32'hA1);
      idle_cycles(1);

      // Slave stalls with p_ready low.
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = ADDR_RW; cmd_wdata = 32'h0;
      @(negedge p_clk);
      last_addr = ADDR_RW; last_write = 1'b0; last_wdata = 32'h0;
      cmd_valid = 1'b0; p_ready = 1'b0;
      @(negedge p_clk);
`ifdef APB_TIMEOUT_EN
      for (int k = 1; k < 16; k++) begin
         @(negedge p_clk);
         chk("timeout_wait_rsp_valid", rsp_valid, 0);
         chk("timeout_wait_p_sel", p_sel, 1);
      end
      @(negedge p_clk);
      chk("timeout_rsp_valid", rsp_valid, 1);
      chk("timeout_rsp_err", rsp_err, 1);
      chk("timeout_rsp_rdata", rsp_rdata, 0);
      chk("timeout_p_sel", p_sel, 0);
      chk("timeout_p_enable", p_enable, 0);
      last_rdata = 32'h0; last_err = 1'b1;
`else
      for (int k = 1; k <= 20; k++) begin
         @(negedge p_clk);
         chk("stall_rsp_valid", rsp_valid, 0);
         chk("stall_p_sel", p_sel, 1);
         chk("stall_p_enable", p_enable, 1);
      end
      slave_model(1'b0, ADDR_RW, 32'h0, rd, er);
      p_ready = 1'b1; p_r_data = rd; p_slv_err = er;
      @(negedge p_clk);
      p_ready = 1'b0;
      chk("stall_end_rsp_valid", rsp_valid, 1);
      chk("stall_end_rsp_rdata", rsp_rdata, 32'hA1);
      last_rdata = rd; last_err = er;
`endif
      idle_cycles(2);

      // Random traffic against the register model.
      for (int n = 0; n < 40; n++) begin
         xfer(1'($urandom), 2'($urandom), $urandom, int'($urandom_range(0, 4)),
              1'($urandom));
         if (($urandom % 3) == 0) idle_cycles(int'($urandom_range(1, 2)));
      end
      idle_cycles(1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
